prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter N, default 16, instruction word width in bits.
REQ-002 Parameter M, default 1024, instruction memory depth in words.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a load session from IDLE, ignored in any other state.
REQ-006 byte_in  input  8  serial program byte.
REQ-007 byte_valid  input  1  byte_in is valid.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-009 mem_addr  output  N  instruction memory write address.
REQ-010 mem_wdata  output  N  instruction memory write data.
REQ-011 mem_we  output  1  instruction memory write enable, one-cycle pulses.
REQ-012 cpu_run  output  1  high releases the CPU; low holds it stopped.
REQ-013 done  output  1  load completed successfully; held until reset or next start.
REQ-014 err  output  1  load aborted on length overflow; held until reset or next start.
REQ-015 words_loaded  output  N  count of words written this session.

Function
REQ-016 A byte transfers only on a cycle where byte_valid and byte_ready are both high.
REQ-017 Stream format: 2-byte length L, high byte first, then L words, each sent high byte first.
REQ-018 States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR.
REQ-019 IDLE -> LEN_HI on start; start also clears done, err and words_loaded.
REQ-020 LEN_HI -> LEN_LO on transfer; LEN_LO -> DATA_HI on transfer when 1 <= L <= M-1.
REQ-021 LEN_LO -> DONE on transfer when L = 0; no memory write occurs.
REQ-022 LEN_LO -> ERR on transfer when L > M-1, since address 0 is reserved as the halt address; no write occurs.
REQ-023 DATA_HI -> DATA_LO on transfer; DATA_LO -> WRITE on transfer.
REQ-024 In WRITE, for exactly one cycle: mem_we = 1, mem_addr = words_loaded + 1, mem_wdata = {hi, lo}; words_loaded increments at the end of the cycle.
REQ-025 Write addresses run 1..L in order; address 0 is never written.
REQ-026 WRITE -> DATA_HI if the incremented count < L, else -> DONE.
REQ-027 byte_ready = 1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO; it is 0 in IDLE, WRITE, DONE and ERR.
REQ-028 Latency: the write pulse occurs the cycle after the low data byte is accepted; minimum 3 cycles per word.
REQ-029 cpu_run = 1 only in DONE; it is 0 in every other state, including ERR.
REQ-030 DONE and ERR return to LEN_HI on start.
REQ-031 Stalls (byte_valid low) hold all state indefinitely; no timeout.
REQ-032 mem_addr and mem_wdata hold their last values when mem_we = 0.
REQ-033 Arithmetic is unsigned, N bits; L is zero-extended from 16 bits to N bits.

Reset
REQ-034 rst_n low asynchronously forces: state IDLE; byte_ready, mem_we, cpu_run, done and err 0; mem_addr, mem_wdata and words_loaded 0.
REQ-035 Reset mid-session abandons the load; no write pulse is emitted after rst_n falls, and partially written memory is left as is.

Structure
REQ-036 A shared package holds the N and M defaults and the loader state enumeration.
REQ-037 One sub-module, word_pack, assembles the hi and lo bytes into an N-bit word (register plus concatenation); the FSM stays in prog_loader.

Verification
REQ-038 Load L=3, words 0x8005, 0xA000, 0x0000 -> writes to addresses 1, 2, 3 with those values, words_loaded=3, done=1, cpu_run=1.
REQ-039 L=0 -> no mem_we pulse, done=1 one cycle after the second byte, words_loaded=0.
REQ-040 L=1024 with M=1024 -> err=1, cpu_run=0, no mem_we pulse; a following start and L=1 load succeeds.
REQ-041 L=2 with byte_valid dropped for 5 cycles between the hi and lo bytes -> state holds, the correct word is written, and no extra pulses occur.
REQ-042 rst_n asserted during DATA_LO of word 2 -> outputs zero immediately; only word 1 was written; a restart loads cleanly.
REQ-043 start pulsed while in DATA_HI -> ignored; the session completes unchanged.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared defaults and state encoding for the serial program loader.
package prog_loader_pkg;

  localparam int N_DEFAULT = 16;
  localparam int M_DEFAULT = 1024;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_WRITE   = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, instruction-memory write port out.
// Handshake: a byte moves on a rising edge where byte_valid and byte_ready are both high;
// byte_in must be stable while byte_valid is high, and byte_ready never depends on byte_valid.
interface prog_loader_if #(parameter int N = 16);
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_we;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/prog_loader_word_pack.sv
// Holds the high byte of a pair and joins it with the current low byte into one word.
module word_pack #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_hi,
  input  logic [7:0]   byte_in,
  output logic [N-1:0] word
);

  logic [7:0] hi_q, hi_d;

  always_comb begin
    hi_d = load_hi ? byte_in : hi_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hi_q <= '0;
    else        hi_q <= hi_d;
  end

  // Zero-extends the 16-bit pair to the instruction width.
  assign word = N'({hi_q, byte_in});

endmodule

// File: rtl/prog_loader.sv
// Receives a length-prefixed byte stream, writes it to instruction memory from
// address 1 upward, and releases the CPU once the whole program is in place.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int M = M_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  prog_loader_if.slave  bus,
  output logic          cpu_run,
  output logic          done,
  output logic          err,
  output logic [N-1:0]  words_loaded,
  output loader_state_t state_dbg
);

  localparam logic [N:0]   MAX_L = (N+1)'(M - 1);
  localparam logic [N-1:0] ONE   = N'(1);

  loader_state_t state_q, state_d;
  logic [N-1:0]  len_q, len_d;
  logic [N-1:0]  wl_q, wl_d;
  logic [N-1:0]  addr_q, addr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic          we_q, we_d;
  logic          run_q, run_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          xfer, load_hi;
  logic [N-1:0]  word, wl_inc;

  assign xfer    = bus.byte_valid && ready_q;
  assign load_hi = xfer && (state_q == S_LEN_HI || state_q == S_DATA_HI);
  assign wl_inc  = wl_q + ONE;

  word_pack #(.N(N)) u_word_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_hi (load_hi),
    .byte_in (bus.byte_in),
    .word    (word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wl_d    = wl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          wl_d    = '0;
        end
      end
      S_LEN_HI:  if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          len_d = word;
          // Address 0 is the halt address, so at most M-1 words fit.
          if (word == '0)                state_d = S_DONE;
          else if ({1'b0, word} > MAX_L) state_d = S_ERR;
          else                           state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: if (xfer) state_d = S_DATA_LO;
      S_DATA_LO: begin
        if (xfer) begin
          state_d = S_WRITE;
          addr_d  = wl_inc;
          wdata_d = word;
        end
      end
      S_WRITE: begin
        wl_d    = wl_inc;
        state_d = (wl_inc < len_q) ? S_DATA_HI : S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
              (state_d == S_DATA_HI) || (state_d == S_DATA_LO);
    we_d    = (state_d == S_WRITE);
    run_d   = (state_d == S_DONE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wl_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wl_q    <= wl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign cpu_run        = run_q;
  assign done           = done_q;
  assign err            = err_q;
  assign words_loaded   = wl_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: byte driver, write scoreboard, immediate-assertion checks.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          cpu_run;
  logic          done;
  logic          err;
  logic [15:0]   words_loaded;
  loader_state_t state_dbg;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  logic [31:0] exp_q[$];

  prog_loader_if #(.N(16)) bus ();

  prog_loader #(.N(16), .M(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus.slave),
    .cpu_run      (cpu_run),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor / scoreboard: every pulse must match the head of exp_q.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      logic [31:0] e;
      we_count++;
      if (exp_q.size() == 0) e = 32'hDEAD_DEAD;
      else                   e = exp_q.pop_front();
      chk("write_addr_data", {bus.mem_addr, bus.mem_wdata}, e);
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("byte_ready_timeout", 32'(n), 32'd0);
    else begin
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst_n = 1'b0;
    start = 1'b0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("rst_flags", {28'd0, bus.mem_we, cpu_run, done, err}, 32'd0);
    chk("rst_addr_data", {bus.mem_addr, bus.mem_wdata}, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_ready", {31'd0, bus.byte_ready}, 32'd0);

    // L=3, three words to addresses 1..3
    exp_q.push_back({16'd1, 16'h8005});
    exp_q.push_back({16'd2, 16'hA000});
    exp_q.push_back({16'd3, 16'h0000});
    pulse_start();
    chk("len_hi_ready", {31'd0, bus.byte_ready}, 32'd1);
    send_word(16'd3);
    send_word(16'h8005);
    send_word(16'hA000);
    send_word(16'h0000);
    wait_done("l3_done");
    chk("l3_words", 32'(words_loaded), 32'd3);
    chk("l3_cpu_run", {31'd0, cpu_run}, 32'd1);
    chk("l3_err", {31'd0, err}, 32'd0);
    chk("l3_ready_low", {31'd0, bus.byte_ready}, 32'd0);
    chk("l3_we_count", 32'(we_count), 32'd3);
    chk("l3_addr_hold", {bus.mem_addr, bus.mem_wdata}, {16'd3, 16'h0000});

    // L=0: done right after second byte, no writes
    base = we_count;
    pulse_start();
    chk("restart_clears_done", {30'd0, done, cpu_run}, 32'd0);
    send_word(16'd0);
    chk("l0_done", {31'd0, done}, 32'd1);
    chk("l0_words", 32'(words_loaded), 32'd0);
    chk("l0_no_write", 32'(we_count - base), 32'd0);

    // L=1024: overflow
    pulse_start();
    send_word(16'd1024);
    chk("ovf_state", 32'(state_dbg), 32'(S_ERR));
    chk("ovf_flags", {29'd0, err, done, cpu_run}, 32'b100);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_no_write", 32'(we_count - base), 32'd0);

    // recovery with L=1
    exp_q.push_back({16'd1, 16'h1234});
    pulse_start();
    chk("err_cleared", {31'd0, err}, 32'd0);
    send_word(16'd1);
    send_word(16'h1234);
    wait_done("l1_done");
    chk("l1_words", 32'(words_loaded), 32'd1);
    chk("l1_we_count", 32'(we_count - base), 32'd1);

    // L=2 with a 5-cycle stall inside the first word
    base = we_count;
    exp_q.push_back({16'd1, 16'hBEEF});
    exp_q.push_back({16'd2, 16'h0102});
    pulse_start();
    send_word(16'd2);
    send_byte(8'hBE);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_state", 32'(state_dbg), 32'(S_DATA_LO));
    chk("stall_no_write", 32'(we_count - base), 32'd0);
    send_byte(8'hEF);
    send_word(16'h0102);
    wait_done("stall_done");
    chk("stall_words", 32'(words_loaded), 32'd2);
    chk("stall_we_count", 32'(we_count - base), 32'd2);

    // reset during DATA_LO of word 2
    base = we_count;
    exp_q.push_back({16'd1, 16'h1111});
    pulse_start();
    send_word(16'd3);
    send_word(16'h1111);
    send_byte(8'h22);
    chk("mid_state", 32'(state_dbg), 32'(S_DATA_LO));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("mid_rst_flags", {27'd0, bus.byte_ready, bus.mem_we, cpu_run, done, err}, 32'd0);
    chk("mid_rst_bus", {bus.mem_addr, bus.mem_wdata}, 32'd0);
    chk("mid_rst_words", 32'(words_loaded), 32'd0);
    bus.byte_in = 8'h22;
    bus.byte_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_one_write", 32'(we_count - base), 32'd1);
    chk("mid_exp_empty", 32'(exp_q.size()), 32'd0);
    exp_q.push_back({16'd1, 16'h5A5A});
    pulse_start();
    send_word(16'd1);
    send_word(16'h5A5A);
    wait_done("after_rst_done");
    chk("after_rst_words", 32'(words_loaded), 32'd1);

    // start while in DATA_HI is ignored
    base = we_count;
    exp_q.push_back({16'd1, 16'h0A0B});
    exp_q.push_back({16'd2, 16'h0C0D});
    pulse_start();
    send_word(16'd2);
    chk("pre_start_state", 32'(state_dbg), 32'(S_DATA_HI));
    pulse_start();
    chk("ignored_start_state", 32'(state_dbg), 32'(S_DATA_HI));
    send_word(16'h0A0B);
    send_word(16'h0C0D);
    wait_done("ign_done");
    chk("ign_words", 32'(words_loaded), 32'd2);
    chk("ign_we_count", 32'(we_count - base), 32'd2);

    repeat (3) @(posedge clk);
    #1;
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("final_done_held", {31'd0, done}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
